logic_reduce_pipe: RTL and testbench

Parametrised successor to the 2-input OR whitebox cell: CHANNELS independent WIDTH-input reductions with a selectable function (OR/AND/XOR).
- Output passes through a 0..3-stage valid-tagged pipeline.
- Optional sticky accumulation across transactions.
- Used as a whitebox test cell for v2x with FASM_FEATURES "IN_USE;ENABLE_FEATURE_X" plus "STICKY" when STICKY=1.

---
 rtl/logic_reduce_pkg.sv | 35 +++
 rtl/logic_reduce_stage.sv | 35 +++
 rtl/logic_reduce_pipe.sv | 123 ++++++++++++
 tb/tb_logic_reduce_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// Shared constants and reduction helpers for the logic_reduce_pipe whitebox cell.
package logic_reduce_pkg;

  localparam int FUNC_OR         = 0;
  localparam int FUNC_AND        = 1;
  localparam int FUNC_XOR        = 2;
  localparam int MAX_PIPE_STAGES = 3;
  // Upper bound on WIDTH; the reduce helper works on a zero-padded vector of this size.
  localparam int MAX_RED_W       = 64;

  function automatic logic reduce_bits(input int func, input logic [MAX_RED_W-1:0] v,
                                       input int w);
    logic acc;
    acc = (func == FUNC_AND);
    for (int i = 0; i < MAX_RED_W; i++) begin
      if (i < w) begin
        case (func)
          FUNC_AND: acc &= v[i];
          FUNC_XOR: acc ^= v[i];
          default:  acc |= v[i];
        endcase
      end
    end
    return acc;
  endfunction

  function automatic logic fold_bit(input int func, input logic a, input logic b);
    case (func)
      FUNC_AND: return a & b;
      FUNC_XOR: return a ^ b;
      default:  return a | b;
    endcase
  endfunction

endpackage

// File: rtl/logic_reduce_stage.sv
// One valid-tagged register stage of the reduction pipeline.
// Optional clock enable port exists only when LOGIC_REDUCE_CE_EN is defined.
module logic_reduce_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef LOGIC_REDUCE_CE_EN
  input  logic         ce,
`endif
  input  logic [W-1:0] d,
  input  logic         v_in,
  output logic [W-1:0] q,
  output logic         v_out
);

  logic en;
`ifdef LOGIC_REDUCE_CE_EN
  assign en = ce;
`else
  assign en = 1'b1;
`endif

  // Data loads only on valid beats so the last result is held through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      v_out <= 1'b0;
    end else if (en) begin
      v_out <= v_in;
      if (v_in) q <= d;
    end
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// CHANNELS parallel WIDTH-input OR/AND/XOR reductions behind a 0..3 stage pipeline,
// with optional sticky fold in the last stage. Clock enable via LOGIC_REDUCE_CE_EN.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int CHANNELS    = 1,
  parameter int FUNC        = 0,
  parameter int PIPE_STAGES = 1,
  parameter int STICKY      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef LOGIC_REDUCE_CE_EN
  input  logic                      ce,
`endif
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic                      clr,
  output logic [CHANNELS-1:0]       O,
  output logic                      out_valid
);

  // Handshake: in_valid/out_valid only qualify data; there is no ready, so a beat
  // is accepted on every enabled cycle and a result appears exactly PIPE_STAGES later.

  if (WIDTH < 1 || WIDTH > MAX_RED_W) begin : g_bad_width
    $error("logic_reduce_pipe: WIDTH out of range");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("logic_reduce_pipe: CHANNELS must be >= 1");
  end
  if (FUNC < FUNC_OR || FUNC > FUNC_XOR) begin : g_bad_func
    $error("logic_reduce_pipe: FUNC must be 0, 1 or 2");
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $error("logic_reduce_pipe: PIPE_STAGES must be 0..3");
  end
  if (STICKY != 0 && PIPE_STAGES < 1) begin : g_bad_sticky
    $error("logic_reduce_pipe: STICKY needs PIPE_STAGES >= 1");
  end

  // The sticky accumulator replaces the final plain stage.
  localparam int N_REG_RAW = (STICKY != 0) ? PIPE_STAGES - 1 : PIPE_STAGES;
  localparam int N_REG     = (N_REG_RAW < 0) ? 0 : N_REG_RAW;

  logic ce_on;
`ifdef LOGIC_REDUCE_CE_EN
  assign ce_on = ce;
`else
  assign ce_on = 1'b1;
`endif

  logic [CHANNELS-1:0] d_chain [0:N_REG];
  logic                v_chain [0:N_REG];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_reduce
    assign d_chain[0][c] = reduce_bits(FUNC, MAX_RED_W'(I[c*WIDTH +: WIDTH]), WIDTH);
  end
  assign v_chain[0] = in_valid;

  for (genvar s = 0; s < N_REG; s++) begin : g_stage
    logic_reduce_stage #(.W(CHANNELS)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef LOGIC_REDUCE_CE_EN
      .ce    (ce_on),
`endif
      .d     (d_chain[s]),
      .v_in  (v_chain[s]),
      .q     (d_chain[s+1]),
      .v_out (v_chain[s+1])
    );
  end

  if (PIPE_STAGES == 0) begin : g_comb
    logic unused_comb;
    assign unused_comb = clk ^ rst_n ^ clr;
    assign O           = d_chain[0];
    assign out_valid   = v_chain[0] & ce_on;
  end else if (STICKY == 0) begin : g_plain
    logic unused_plain;
    assign unused_plain = clr ^ ce_on;
    assign O            = d_chain[N_REG];
    assign out_valid    = v_chain[N_REG];
  end else begin : g_sticky
    logic [CHANNELS-1:0] acc;
    logic [CHANNELS-1:0] folded;
    logic                primed;
    logic                ov;
    logic [CHANNELS-1:0] tail_d;
    logic                tail_v;

    assign tail_d = d_chain[N_REG];
    assign tail_v = v_chain[N_REG];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_fold
      assign folded[c] = fold_bit(FUNC, acc[c], tail_d[c]);
    end

    // A clear arriving with a beat restarts the fold from that beat, never from zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc    <= '0;
        primed <= 1'b0;
        ov     <= 1'b0;
      end else if (ce_on) begin
        ov <= tail_v;
        if (tail_v) begin
          acc    <= (!primed || clr) ? tail_d : folded;
          primed <= 1'b1;
        end else if (clr) begin
          acc    <= '0;
          primed <= 1'b0;
        end
      end
    end

    assign O         = acc;
    assign out_valid = ov;
  end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Directed bench for logic_reduce_pipe across several parameter sets; ce path
// is exercised when LOGIC_REDUCE_CE_EN is defined.
module tb_logic_reduce_pipe;

  logic clk;
  logic rst_n;
  logic ce;
  int   checks;
  int   errors;

  // u1: legacy 2-input OR, combinational
  logic       iv1;
  logic [1:0] i1;
  logic       clr1;
  logic [0:0] o1;
  logic       ov1;
  // u2: 2 channels x 4-bit XOR, 2 stages
  logic       iv2;
  logic [7:0] i2;
  logic       clr2;
  logic [1:0] o2;
  logic       ov2;
  // u3: AND sticky, 1 stage
  logic       iv3;
  logic [1:0] i3;
  logic       clr3;
  logic [0:0] o3;
  logic       ov3;
  // u4: OR sticky, 1 stage
  logic       iv4;
  logic [1:0] i4;
  logic       clr4;
  logic [0:0] o4;
  logic       ov4;
  // u5: OR, 3 stages
  logic       iv5;
  logic [1:0] i5;
  logic       clr5;
  logic [0:0] o5;
  logic       ov5;

  logic [0:0] exp_or [4];

  logic_reduce_pipe #(.WIDTH(2), .CHANNELS(1), .FUNC(0), .PIPE_STAGES(0), .STICKY(0)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef LOGIC_REDUCE_CE_EN
    .ce(ce),
`endif
    .in_valid(iv1), .I(i1), .clr(clr1), .O(o1), .out_valid(ov1));

  logic_reduce_pipe #(.WIDTH(4), .CHANNELS(2), .FUNC(2), .PIPE_STAGES(2), .STICKY(0)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef LOGIC_REDUCE_CE_EN
    .ce(ce),
`endif
    .in_valid(iv2), .I(i2), .clr(clr2), .O(o2), .out_valid(ov2));

  logic_reduce_pipe #(.WIDTH(2), .CHANNELS(1), .FUNC(1), .PIPE_STAGES(1), .STICKY(1)) u3 (
    .clk(clk), .rst_n(rst_n),
`ifdef LOGIC_REDUCE_CE_EN
    .ce(ce),
`endif
    .in_valid(iv3), .I(i3), .clr(clr3), .O(o3), .out_valid(ov3));

  logic_reduce_pipe #(.WIDTH(2), .CHANNELS(1), .FUNC(0), .PIPE_STAGES(1), .STICKY(1)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef LOGIC_REDUCE_CE_EN
    .ce(ce),
`endif
    .in_valid(iv4), .I(i4), .clr(clr4), .O(o4), .out_valid(ov4));

  logic_reduce_pipe #(.WIDTH(2), .CHANNELS(1), .FUNC(0), .PIPE_STAGES(3), .STICKY(0)) u5 (
    .clk(clk), .rst_n(rst_n),
`ifdef LOGIC_REDUCE_CE_EN
    .ce(ce),
`endif
    .in_valid(iv5), .I(i5), .clr(clr5), .O(o5), .out_valid(ov5));

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_or[0] = 1'b0;
    exp_or[1] = 1'b1;
    exp_or[2] = 1'b1;
    exp_or[3] = 1'b1;
    ce   = 1'b1;
    iv1 = 1'b0; i1 = '0; clr1 = 1'b0;
    iv2 = 1'b0; i2 = '0; clr2 = 1'b0;
    iv3 = 1'b0; i3 = '0; clr3 = 1'b0;
    iv4 = 1'b0; i4 = '0; clr4 = 1'b0;
    iv5 = 1'b0; i5 = '0; clr5 = 1'b0;

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov2", 8'(ov2), 8'h0);
    check("rst_o2",  8'(o2),  8'h0);
    check("rst_ov3", 8'(ov3), 8'h0);
    check("rst_o3",  8'(o3),  8'h0);
    check("rst_ov5", 8'(ov5), 8'h0);
    check("rst_o5",  8'(o5),  8'h0);
    #3 rst_n = 1'b1;
    tick();

    // legacy OR truth table, combinational
    for (int k = 0; k < 4; k++) begin
      i1 = 2'(k);
      iv1 = 1'b1;
      #1;
      check($sformatf("or_cell_o_%0d", k), 8'(o1), 8'(exp_or[k]));
      check("or_cell_ov1", 8'(ov1), 8'h1);
    end
    iv1 = 1'b0;
    #1;
    check("or_cell_ov0", 8'(ov1), 8'h0);

    // XOR 2-stage: beat, bubble, beat, bubble
    i2 = 8'b0111_0001; iv2 = 1'b1;
    tick();
    check("xor_lat1_ov", 8'(ov2), 8'h0);
    iv2 = 1'b0; i2 = 8'hff;
    tick();
    check("xor_a_ov", 8'(ov2), 8'h1);
    check("xor_a_o",  8'(o2),  8'h3);
    i2 = 8'b1010_1000; iv2 = 1'b1;
    tick();
    check("xor_bub_ov",  8'(ov2), 8'h0);
    check("xor_bub_hold", 8'(o2), 8'h3);
    iv2 = 1'b0; i2 = 8'h00;
    tick();
    check("xor_b_ov", 8'(ov2), 8'h1);
    check("xor_b_o",  8'(o2),  8'h1);
    tick();
    check("xor_tail_ov", 8'(ov2), 8'h0);

    // AND sticky: 11, 11, 10, then clr with 11
    i3 = 2'b11; iv3 = 1'b1;
    tick();
    check("and_s1_ov", 8'(ov3), 8'h1);
    check("and_s1_o",  8'(o3),  8'h1);
    tick();
    check("and_s2_o", 8'(o3), 8'h1);
    i3 = 2'b10;
    tick();
    check("and_s3_o", 8'(o3), 8'h0);
    i3 = 2'b11; clr3 = 1'b1;
    tick();
    check("and_clr_beat_o",  8'(o3),  8'h1);
    check("and_clr_beat_ov", 8'(ov3), 8'h1);
    iv3 = 1'b0; clr3 = 1'b0;
    tick();
    check("and_idle_ov",   8'(ov3), 8'h0);
    check("and_idle_hold", 8'(o3),  8'h1);

    // OR sticky: 01, 00, 00, clr alone, 00
    i4 = 2'b01; iv4 = 1'b1;
    tick();
    check("or_s1_o", 8'(o4), 8'h1);
    i4 = 2'b00;
    tick();
    check("or_s2_o", 8'(o4), 8'h1);
    tick();
    check("or_s3_o", 8'(o4), 8'h1);
    iv4 = 1'b0; clr4 = 1'b1;
    tick();
    check("or_clr_o",  8'(o4),  8'h0);
    check("or_clr_ov", 8'(ov4), 8'h0);
    clr4 = 1'b0; iv4 = 1'b1; i4 = 2'b00;
    tick();
    check("or_after_clr_o",  8'(o4),  8'h0);
    check("or_after_clr_ov", 8'(ov4), 8'h1);
    iv4 = 1'b0;

`ifdef LOGIC_REDUCE_CE_EN
    // clock enable stalls the 2-stage pipe for two cycles
    i2 = 8'b0111_0001; iv2 = 1'b1;
    tick();
    ce = 1'b0; i2 = 8'h0f;
    tick();
    tick();
    check("ce_frozen_ov", 8'(ov2), 8'h0);
    ce = 1'b1; iv2 = 1'b0;
    tick();
    check("ce_resume_ov", 8'(ov2), 8'h1);
    check("ce_resume_o",  8'(o2),  8'h3);
    tick();
    check("ce_ignored_iv", 8'(ov2), 8'h0);
`endif

    // 3-stage: latency, hold, then asynchronous mid-pipeline reset
    i5 = 2'b11; iv5 = 1'b1;
    tick();
    iv5 = 1'b0;
    tick();
    check("p3_lat2_ov", 8'(ov5), 8'h0);
    tick();
    check("p3_lat3_ov", 8'(ov5), 8'h1);
    check("p3_lat3_o",  8'(o5),  8'h1);
    tick();
    check("p3_hold_ov", 8'(ov5), 8'h0);
    check("p3_hold_o",  8'(o5),  8'h1);
    i5 = 2'b01; iv5 = 1'b1;
    tick();
    i5 = 2'b10;
    tick();
    i5 = 2'b11;
    tick();
    iv5 = 1'b0;
    check("p3_pre_rst_ov", 8'(ov5), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    check("p3_async_rst_o",  8'(o5),  8'h0);
    check("p3_async_rst_ov", 8'(ov5), 8'h0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("p3_post_rst_ov_%0d", k), 8'(ov5), 8'h0);
      check($sformatf("p3_post_rst_o_%0d", k),  8'(o5),  8'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
